// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: grant identity and the
// two-way round-robin pick function.
package wb_arbiter_pkg;

    // Identity of the requester that won the most recent transfer.
    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

    // Returns {grant1, grant0}. A lone requester always wins; under
    // contention the requester that did not win last time is chosen.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1,
                                           input grant_e last);
        logic [1:0] g;
        g = '0;
        if (v0 && !v1) begin
            g = 2'b01;
        end else if (!v0 && v1) begin
            g = 2'b10;
        end else if (v0 && v1) begin
            g = (last == GRANT_REQ1) ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin grant. Ready is combinational from the valids and
// the last-grant pointer; the pointer moves only when a transfer happens.
module wb_arbiter_rr_arb2
    import wb_arbiter_pkg::*;
(
    input  logic r_clk,
    input  logic r_rst,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);

    grant_e     last_grant;
    grant_e     last_grant_next;
    logic [1:0] pick;

    // Pointer register; reset makes req0 win the first contention.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            last_grant <= GRANT_REQ1;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Grant decode and pointer update; readies are forced low during reset.
    always_comb begin
        pick            = rr_pick(valid0, valid1, last_grant);
        ready0          = r_rst & pick[0];
        ready1          = r_rst & pick[1];
        last_grant_next = last_grant;
        if (ready0) begin
            last_grant_next = GRANT_REQ0;
        end else if (ready1) begin
            last_grant_next = GRANT_REQ1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load writebacks onto the single
// register-file write port and keeps a pending-write scoreboard that
// stalls decode on unresolved source operands.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic                     r_clk,
    input  logic                     r_rst,
    input  logic                     req0_valid,
    input  logic [AWIDTH-1:0]        req0_addr,
    input  logic [DWIDTH-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [AWIDTH-1:0]        req1_addr,
    input  logic [DWIDTH-1:0]        req1_data,
    output logic                     req1_ready,
    input  logic                     iss_en,
    input  logic [AWIDTH-1:0]        iss_addr,
    input  logic [AWIDTH-1:0]        rs_addr,
    input  logic [AWIDTH-1:0]        rt_addr,
    output logic                     wr_en,
    output logic [AWIDTH-1:0]        wr_addr,
    output logic [DWIDTH-1:0]        wr_data,
    output logic [(1<<AWIDTH)-1:0]   pend_vec,
    output logic                     stall
);

    localparam int NREG = 1 << AWIDTH;

    logic              xfer;
    logic              write;
    logic [AWIDTH-1:0] xfer_addr;
    logic [DWIDTH-1:0] xfer_data;
    logic [NREG-1:0]   pend_next;

    wb_arbiter_rr_arb2 u_rr_arb2 (
        .r_clk  (r_clk),
        .r_rst  (r_rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ready0 (req0_ready),
        .ready1 (req1_ready)
    );

    // Select the accepted request; a ready is only raised alongside its valid.
    always_comb begin
        xfer      = req0_ready | req1_ready;
        xfer_addr = req1_ready ? req1_addr : req0_addr;
        xfer_data = req1_ready ? req1_data : req0_data;
        write     = xfer && (xfer_addr != '0);
    end

    // Register-file write port: one-cycle pulse, address/data hold otherwise.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= write;
            if (write) begin
                wr_addr <= xfer_addr;
                wr_data <= xfer_data;
            end
        end
    end

    // Scoreboard next state: clear applied first so a same-cycle issue wins.
    always_comb begin
        pend_next = pend_vec;
        if (write) begin
            pend_next[xfer_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != '0)) begin
            pend_next[iss_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            pend_vec <= '0;
        end else begin
            pend_vec <= pend_next;
        end
    end

    // Decode hold: any nonzero source register still awaiting writeback.
    always_comb begin
        stall = ((rs_addr != '0) && pend_vec[rs_addr])
              | ((rt_addr != '0) && pend_vec[rt_addr]);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run against a behavioural reference model.
module tb_wb_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic            clk;
    logic            r_rst;
    logic            req0_valid, req1_valid;
    logic [AW-1:0]   req0_addr, req1_addr;
    logic [DW-1:0]   req0_data, req1_data;
    logic            req0_ready, req1_ready;
    logic            iss_en;
    logic [AW-1:0]   iss_addr, rs_addr, rt_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] pend_vec;
    logic            stall;

    int total = 0;
    int bad   = 0;

    // reference model state
    int            m_last;          // requester (0/1) that won the last transfer
    logic [NREG-1:0] m_pend;
    logic          m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic          m_r0, m_r1, m_stall;

    // register file as seen by the write port
    logic [DW-1:0] rf [NREG];

    wb_arbiter #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .r_clk(clk), .r_rst(r_rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .iss_en(iss_en), .iss_addr(iss_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_vec(pend_vec), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) rf[wr_addr] <= wr_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic ie, input logic [AW-1:0] ia,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        iss_en = ie; iss_addr = ia; rs_addr = rs; rt_addr = rt;
    endtask

    task automatic model_reset();
        m_last = 1; m_pend = '0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    endtask

    // Combinational view: who may transfer now, and whether decode stalls.
    task automatic model_comb();
        m_r0 = 1'b0; m_r1 = 1'b0;
        if (r_rst) begin
            if (req0_valid && !req1_valid)      m_r0 = 1'b1;
            else if (req1_valid && !req0_valid) m_r1 = 1'b1;
            else if (req0_valid && req1_valid) begin
                if (m_last == 1) m_r0 = 1'b1; else m_r1 = 1'b1;
            end
        end
        m_stall = (rs_addr != 0 && m_pend[rs_addr]) || (rt_addr != 0 && m_pend[rt_addr]);
    endtask

    // Clock edge effects of the transfer decided by model_comb.
    task automatic model_clock();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        m_wr_en = 1'b0;
        if (m_r0 || m_r1) begin
            a = m_r0 ? req0_addr : req1_addr;
            d = m_r0 ? req0_data : req1_data;
            m_last = m_r0 ? 0 : 1;
            if (a != 0) begin
                m_wr_en = 1'b1; m_wr_addr = a; m_wr_data = d;
                m_pend[a] = 1'b0;
            end
        end
        if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    endtask

    task automatic test_reset();
        r_rst = 1'b0;
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 1'b0, '0, '0, '0);
        model_reset();
        #2;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        total++; if (pend_vec !== '0) begin bad++; $display("FAIL reset_pend got=%h exp=0", pend_vec); end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_contention();
        logic [DW-1:0] d0, d1;
        int exp_win;
        d0 = 32'hAAAA; d1 = 32'hBBBB;
        @(negedge clk);
        r_rst = 1'b1;
        drive(1'b1, 5'd3, d0, 1'b1, 5'd4, d1, 1'b0, '0, '0, '0);
        for (int k = 0; k < 6; k++) begin
            exp_win = k % 2;
            #1; model_comb();
            total++; if (req0_ready !== (exp_win == 0) || req1_ready !== (exp_win == 1)) begin
                bad++; $display("FAIL contention_ready k=%0d got=%b%b exp_winner=req%0d", k, req0_ready, req1_ready, exp_win); end
            @(posedge clk); model_clock(); #1;
            total++; if (wr_en !== 1'b1 || wr_addr !== (exp_win == 0 ? 5'd3 : 5'd4)
                         || wr_data !== (exp_win == 0 ? d0 : d1)) begin
                bad++; $display("FAIL contention_write k=%0d got en=%b a=%0d d=%h", k, wr_en, wr_addr, wr_data); end
            @(negedge clk);
            if (exp_win == 0) d0 = d0 + 1; else d1 = d1 + 1;
            drive(1'b1, 5'd3, d0, 1'b1, 5'd4, d1, 1'b0, '0, '0, '0);
        end
        #1;
        total++; if (rf[3] !== 32'hAAAC || rf[4] !== 32'hBBBD) begin
            bad++; $display("FAIL contention_rf got r3=%h r4=%h exp r3=aaac r4=bbbd", rf[3], rf[4]); end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, '0);
        #1; model_comb();
        total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            bad++; $display("FAIL zero_ready got=%b%b exp=01", req0_ready, req1_ready); end
        @(posedge clk); model_clock(); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL zero_wr_en got=%b exp=0", wr_en); end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_scoreboard();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, '0);
        #1; model_comb();
        @(posedge clk); model_clock(); #1;
        total++; if (pend_vec[7] !== 1'b1) begin bad++; $display("FAIL sb_set got=%b exp=1", pend_vec[7]); end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 5'd7, '0);
        #1; model_comb();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_rs got=%b exp=1", stall); end
        @(posedge clk); model_clock();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h7777, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd12);
        #1; model_comb();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_stall_rt got=%b exp=1", stall); end
        rs_addr = 5'd7; rt_addr = 5'd0; #1; model_comb();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_no_bypass got=%b exp=1", stall); end
        @(posedge clk); model_clock(); #1;
        total++; if (pend_vec[7] !== 1'b0 || pend_vec[12] !== 1'b1) begin
            bad++; $display("FAIL sb_clear got p7=%b p12=%b exp p7=0 p12=1", pend_vec[7], pend_vec[12]); end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
        #1; model_comb();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sb_stall_release got=%b exp=0", stall); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h9999, 1'b0, '0, '0, 1'b1, 5'd9, '0, '0);
        #1; model_comb();
        @(posedge clk); model_clock(); #1;
        total++; if (pend_vec[9] !== 1'b1) begin bad++; $display("FAIL collision_pend got=%b exp=1", pend_vec[9]); end
        total++; if (wr_en !== 1'b1 || wr_addr !== 5'd9) begin
            bad++; $display("FAIL collision_write got en=%b a=%0d exp en=1 a=9", wr_en, wr_addr); end
    endtask

    task automatic test_sustained();
        logic [DW-1:0] exp_d [9];
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_d[i] = $urandom;
            drive(1'b0, '0, '0, 1'b1, 5'(i), exp_d[i], 1'b0, '0, '0, '0);
            #1; model_comb();
            total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL sustain_ready i=%0d got=%b exp=1", i, req1_ready); end
            @(posedge clk); model_clock(); #1;
            total++; if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_d[i]) begin
                bad++; $display("FAIL sustain_write i=%0d got en=%b a=%0d d=%h exp a=%0d d=%h",
                                i, wr_en, wr_addr, wr_data, i, exp_d[i]); end
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        #1;
        for (int i = 1; i <= 8; i++) begin
            total++; if (rf[i] !== exp_d[i]) begin
                bad++; $display("FAIL sustain_rf r%0d got=%h exp=%h", i, rf[i], exp_d[i]); end
        end
    endtask

    task automatic test_random();
        logic h0, h1;
        h0 = 1'b0; h1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!h0) begin
                req0_valid = 1'($urandom_range(1, 0));
                req0_addr  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(NREG - 1, 0));
                req0_data  = $urandom;
            end
            if (!h1) begin
                req1_valid = 1'($urandom_range(1, 0));
                req1_addr  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(NREG - 1, 0));
                req1_data  = $urandom;
            end
            iss_en   = ($urandom_range(9, 0) < 3);
            iss_addr = 5'($urandom_range(NREG - 1, 0));
            rs_addr  = 5'($urandom_range(NREG - 1, 0));
            rt_addr  = 5'($urandom_range(NREG - 1, 0));
            #1; model_comb();
            total++; if (req0_ready !== m_r0 || req1_ready !== m_r1) begin
                bad++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, req0_ready, req1_ready, m_r0, m_r1); end
            total++; if (stall !== m_stall) begin
                bad++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, stall, m_stall); end
            h0 = req0_valid && !m_r0;
            h1 = req1_valid && !m_r1;
            @(posedge clk); model_clock(); #1;
            total++; if (wr_en !== m_wr_en) begin
                bad++; $display("FAIL rand_wr_en c=%0d got=%b exp=%b", c, wr_en, m_wr_en); end
            if (m_wr_en) begin
                total++; if (wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
                    bad++; $display("FAIL rand_wr c=%0d got a=%0d d=%h exp a=%0d d=%h",
                                    c, wr_addr, wr_data, m_wr_addr, m_wr_data); end
            end
            total++; if (pend_vec !== m_pend) begin
                bad++; $display("FAIL rand_pend c=%0d got=%h exp=%h", c, pend_vec, m_pend); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h5555, 1'b1, 5'd6, 32'h6666, 1'b1, 5'd11, '0, '0);
        #1; model_comb();
        @(posedge clk); model_clock();
        #2;
        r_rst = 1'b0;
        #1;
        model_reset();
        total++; if (wr_en !== 1'b0 || pend_vec !== '0) begin
            bad++; $display("FAIL midreset_state got en=%b pend=%h exp en=0 pend=0", wr_en, pend_vec); end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        @(negedge clk);
        r_rst = 1'b1;
        drive(1'b1, 5'd5, 32'h5555, 1'b1, 5'd6, 32'h6666, 1'b0, '0, '0, '0);
        #1; model_comb();
        @(posedge clk); model_clock(); #1;
        total++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'h5555) begin
            bad++; $display("FAIL postreset_first got en=%b a=%0d d=%h exp en=1 a=5 d=5555",
                            wr_en, wr_addr, wr_data); end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_sustained();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DWIDTH, default `DWIDTH (32), data width of register-file write data.
REQ-002 Parameter AWIDTH, default `AWIDTH (5), register address width; NREG = 1<<AWIDTH.
REQ-003 r_clk  in  1  clock; all state updates on posedge.
REQ-004 r_rst  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req0_addr / req0_data  in  1 / AWIDTH / DWIDTH  ALU writeback request.
REQ-006 req0_ready  out  1  req0 accepted this cycle.
REQ-007 req1_valid / req1_addr / req1_data  in  1 / AWIDTH / DWIDTH  load/memory writeback request.
REQ-008 req1_ready  out  1  req1 accepted this cycle.
REQ-009 iss_en / iss_addr  in  1 / AWIDTH  decode issues an instruction whose destination is iss_addr.
REQ-010 rs_addr / rt_addr  in  AWIDTH each  source operands of the instruction in decode.
REQ-011 wr_en / wr_addr / wr_data  out  1 / AWIDTH / DWIDTH  register-file write port; registered.
REQ-012 pend_vec  out  NREG  pending-write scoreboard, bit i = register i awaiting writeback.
REQ-013 stall  out  1  decode must hold: a source register is pending.

Function
REQ-014 Handshake: a request transfers when valid & ready in the same cycle; requester holds addr/data stable while valid & !ready.
REQ-015 Ready is combinational from valids and the round-robin pointer; at most one ready high per cycle.
REQ-016 Only one valid: that requester is granted, regardless of pointer.
REQ-017 Both valid: grant the requester not granted last (last_grant pointer); pointer updates only on a transfer.
REQ-018 Neither valid: no grant; pointer unchanged.
REQ-019 Transfer at posedge N: wr_en=1, wr_addr, wr_data valid from posedge N until posedge N+1 (one-cycle pulse), so the register file captures it on the intervening negedge.
REQ-020 Transfer with addr 0: accepted (ready=1), wr_en stays 0 -- register 0 is never written.
REQ-021 No transfer: wr_en=0 next cycle; wr_addr/wr_data hold last value.
REQ-022 Scoreboard: iss_en with iss_addr!=0 sets pend_vec[iss_addr] at posedge; iss_addr=0 ignored.
REQ-023 Transfer to addr a!=0 clears pend_vec[a] at the same posedge.
REQ-024 Simultaneous set and clear of the same address: set wins (newer producer outstanding).
REQ-025 Set of an already-pending bit: stays set; clear of a non-pending bit: no effect, no error.
REQ-026 stall = (rs_addr!=0 & pend_vec[rs_addr]) | (rt_addr!=0 & pend_vec[rt_addr]); combinational, no bypass.
REQ-027 Throughput: one write per cycle sustained; the losing requester waits at most one cycle when both are continuously valid.

Reset
REQ-028 r_rst low: wr_en=0, wr_addr=0, wr_data=0, pend_vec=0, last_grant=1 (req0 wins first contention), immediately, independent of clock.
REQ-029 Ready outputs low while r_rst low; in-flight requests are dropped and must be re-presented after reset.
REQ-030 First posedge after r_rst rises behaves as normal operation; no extra idle cycle.

Structure
REQ-031 DWIDTH/AWIDTH come from the shared header.vh; no new package constants.
REQ-032 One sub-module is natural: rr_arb2 (two-way round-robin grant with pointer); the scoreboard stays inline.
REQ-033 Outputs drive the register file write port directly (wr_en->r_wr_en, wr_addr->r_addr_in, wr_data->r_data_in).

Verification
REQ-034 Reset: r_rst low mid-transfer -> wr_en=0, pend_vec=0, both ready=0 within the same cycle.
REQ-035 Contention: req0 (addr 3, 0xAAAA) and req1 (addr 4, 0xBBBB) held valid from reset -> cycle 1 writes r3=0xAAAA, cycle 2 writes r4=0xBBBB, then alternating for new data.
REQ-036 Zero register: req1 valid addr 0 data 0x1234 -> req1_ready=1, wr_en stays 0, r0 unchanged.
REQ-037 Scoreboard: iss_en addr 7, then rs_addr=7 -> stall=1; req0 writes addr 7 -> pend_vec[7]=0, stall=0 next cycle.
REQ-038 Set/clear collision: iss_en addr 9 in same cycle req0 transfers addr 9 -> pend_vec[9]=1 afterwards.
REQ-039 Sustained single requester: req1 valid 8 consecutive cycles, addrs 1..8 -> 8 consecutive wr_en pulses, register file holds values in order.
